// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point add/sub datapath.
package fp_pkg;

    localparam int MANT_W = 27;

    typedef enum logic [1:0] {
        OP_ADD    = 2'b00,
        OP_SUB    = 2'b01,
        OP_PASS_A = 2'b10,
        OP_PASS_B = 2'b11
    } op_e;

endpackage

// File: rtl/mag_addsub.sv
// Unsigned magnitude comparator plus add / larger-minus-smaller subtract.
module mag_addsub
    import fp_pkg::*;
#(
    parameter int WIDTH = MANT_W
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH:0]   res_o,
    output logic             a_ge_b_o
);

    always_comb begin
        a_ge_b_o = (a_i >= b_i);
        res_o    = '0;
        if (!sub_i) begin
            res_o = {1'b0, a_i} + {1'b0, b_i};
        end else if (a_ge_b_o) begin
            res_o = {1'b0, a_i - b_i};
        end else begin
            res_o = {1'b0, b_i - a_i};
        end
    end

endmodule

// File: rtl/big_alu.sv
// Sign-magnitude mantissa ALU: op decode, sign resolution and output registers.
module big_alu
    import fp_pkg::*;
#(
    parameter int WIDTH = MANT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] input_a,
    input  logic             sign_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic             sign_b,
    input  logic [1:0]       operation,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             result_sign
);

    op_e             op;
    logic            seb;
    logic            eff_sub;
    logic [WIDTH:0]  mag;
    logic            a_ge_b;
    logic [WIDTH-1:0] result_d, result_q;
    logic            carry_d, carry_q;
    logic            sign_d, sign_q;

    assign op      = op_e'(operation);
    assign seb     = (op == OP_SUB) ? ~sign_b : sign_b;
    assign eff_sub = (sign_a != seb);

    mag_addsub #(.WIDTH(WIDTH)) u_mag (
        .a_i      (input_a),
        .b_i      (input_b),
        .sub_i    (eff_sub),
        .res_o    (mag),
        .a_ge_b_o (a_ge_b)
    );

    always_comb begin
        result_d = '0;
        carry_d  = 1'b0;
        sign_d   = 1'b0;
        unique case (op)
            OP_ADD, OP_SUB: begin
                if (!eff_sub) begin
                    {carry_d, result_d} = mag;
                    sign_d              = sign_a;
                end else if (input_a == input_b) begin
                    // exact cancellation always yields +0
                    result_d = '0;
                    sign_d   = 1'b0;
                end else begin
                    result_d = mag[WIDTH-1:0];
                    sign_d   = a_ge_b ? sign_a : seb;
                end
            end
            OP_PASS_A: begin
                result_d = input_a;
                sign_d   = sign_a;
            end
            OP_PASS_B: begin
                result_d = input_b;
                sign_d   = sign_b;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            sign_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
            sign_q   <= sign_d;
        end
    end

    assign result      = result_q;
    assign carry       = carry_q;
    assign result_sign = sign_q;

endmodule

// File: tb/tb_big_alu.sv
// Directed-vector bench for big_alu.
module tb_big_alu;

    localparam int W = 27;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] input_a;
    logic         sign_a;
    logic [W-1:0] input_b;
    logic         sign_b;
    logic [1:0]   operation;
    logic [W-1:0] result;
    logic         carry;
    logic         result_sign;

    int total;
    int bad;

    big_alu #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .input_a     (input_a),
        .sign_a      (sign_a),
        .input_b     (input_b),
        .sign_b      (sign_b),
        .operation   (operation),
        .result      (result),
        .carry       (carry),
        .result_sign (result_sign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] er,
                         input logic ec, input logic es);
        total++;
        assert (result === er) else begin
            bad++;
            $error("FAIL %s result got=%0h exp=%0h", tag, result, er);
        end
        total++;
        assert (carry === ec) else begin
            bad++;
            $error("FAIL %s carry got=%0b exp=%0b", tag, carry, ec);
        end
        total++;
        assert (result_sign === es) else begin
            bad++;
            $error("FAIL %s sign got=%0b exp=%0b", tag, result_sign, es);
        end
    endtask

    task automatic drive(input logic [W-1:0] a, input logic sa,
                         input logic [W-1:0] b, input logic sb,
                         input logic [1:0] op);
        input_a   = a;
        sign_a    = sa;
        input_b   = b;
        sign_b    = sb;
        operation = op;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        drive(27'd5, 1'b0, 27'd11, 1'b0, 2'b00);
        #1 rst_n = 1'b0;
        step();
        step();
        check("reset", 27'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;

        step();
        check("add_5_11", 27'd16, 1'b0, 1'b0);

        drive(27'h7FFFFFF, 1'b0, 27'd1, 1'b0, 2'b00);
        step();
        check("wrap", 27'd0, 1'b1, 1'b0);

        drive(27'd5, 1'b0, 27'd11, 1'b1, 2'b00);
        step();
        check("mixed_add", 27'd6, 1'b0, 1'b1);

        drive(27'd5, 1'b0, 27'd11, 1'b1, 2'b01);
        step();
        check("mixed_sub", 27'd16, 1'b0, 1'b0);

        drive(27'd100, 1'b1, 27'd100, 1'b0, 2'b00);
        step();
        check("equal", 27'd0, 1'b0, 1'b0);

        drive(27'd7, 1'b1, 27'd9, 1'b0, 2'b10);
        step();
        check("pass_a", 27'd7, 1'b0, 1'b1);

        drive(27'd7, 1'b1, 27'd9, 1'b0, 2'b11);
        step();
        check("pass_b", 27'd9, 1'b0, 1'b0);

        drive(27'd20, 1'b1, 27'd3, 1'b1, 2'b01);
        step();
        check("sub_a_big", 27'd17, 1'b0, 1'b1);

        drive(27'd0, 1'b0, 27'd9, 1'b1, 2'b00);
        step();
        check("zero_plus_x", 27'd9, 1'b0, 1'b1);

        drive(27'd0, 1'b1, 27'd0, 1'b1, 2'b00);
        step();
        check("neg_zero", 27'd0, 1'b0, 1'b1);

        drive(27'h4000000, 1'b1, 27'h4000001, 1'b0, 2'b01);
        step();
        check("sub_wrap_neg", 27'h0000001, 1'b1, 1'b1);

        drive(27'd123, 1'b0, 27'd23, 1'b0, 2'b01);
        step();
        check("sub_plain", 27'd100, 1'b0, 1'b0);

        drive(27'd40, 1'b0, 27'd2, 1'b0, 2'b00);
        #3 rst_n = 1'b0;
        #1;
        check("reset_mid", 27'd0, 1'b0, 1'b0);
        step();
        check("reset_hold", 27'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        #1;
        check("reset_release", 27'd0, 1'b0, 1'b0);
        step();
        check("after_reset", 27'd42, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/big_alu.md
Name: big_alu

Overview:
- Sign-magnitude mantissa ALU for the floating-point add/sub datapath.
- Takes two 27-bit magnitudes, each with a sign bit (24-bit significand plus guard, round and sticky bits), applies the requested operation, and registers the magnitude result, carry-out and result sign.
- Sits after exponent alignment and before normalization/rounding.

Parameters:
- WIDTH, 27, magnitude width of operands and result.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- input_a  input  WIDTH  magnitude of operand A.
- sign_a  input  1  sign of A (1 = negative).
- input_b  input  WIDTH  magnitude of operand B.
- sign_b  input  1  sign of B (1 = negative).
- operation  input  2  00 add, 01 subtract, 10 pass A, 11 pass B.
- result  output  WIDTH  magnitude of the result.
- carry  output  1  carry-out of magnitude addition (normalizer shifts right by 1 when set).
- result_sign  output  1  sign of the result.

Behaviour:
- Reset: rst_n low asynchronously clears result, carry and result_sign to 0. They stay 0 while rst_n is low.
- Timing: inputs are sampled every rising clk edge. Outputs are registered with 1-cycle latency.
- No handshake: the block produces a new result every cycle, and back-to-back operations are allowed.
- Effective sign of B: seb = sign_b for op 00, seb = ~sign_b for op 01.
- Ops 00/01, same signs (sign_a == seb):
  - {carry, result} = input_a + input_b, computed at WIDTH+1 bits.
  - result_sign = sign_a.
  - Wrap-around: carry = 1 and result holds the low WIDTH bits.
- Ops 00/01, different signs:
  - Compare magnitudes unsigned.
  - If input_a > input_b: result = a - b, result_sign = sign_a.
  - If input_b > input_a: result = b - a, result_sign = seb.
  - carry = 0 in both cases.
  - Equal magnitudes: result = 0, result_sign = 0 (+0).
- Op 10: result = input_a, result_sign = sign_a, carry = 0.
- Op 11: result = input_b, result_sign = sign_b, carry = 0.
- Zero operands: 0 + x returns x with x's sign. -0 + -0 returns 0 with sign 1 (same-sign path).
- Width rules: all arithmetic is unsigned on magnitudes. Subtraction never borrows because the larger magnitude is always the minuend.
- Reset asserted mid-operation: the pending result is discarded and outputs are 0. The first valid result appears one edge after rst_n deasserts.

Decomposition:
- Shared package fp_pkg:
  - MANT_W = 27 (WIDTH default).
  - Op codes OP_ADD=2'b00, OP_SUB=2'b01, OP_PASS_A=2'b10, OP_PASS_B=2'b11.
- One sub-module, mag_addsub: a combinational comparator plus add/subtract. It returns a WIDTH+1-bit sum/difference and an a_ge_b flag.
- big_alu holds the op decode, sign logic and output registers.

Test Plan:
- Addition: a=5 +, b=11 +, op 00 -> next edge result=16, carry=0, sign=0.
- Wrap-around: a=27'h7FFFFFF +, b=1 +, op 00 -> result=0, carry=1, sign=0.
- Mixed signs: a=5 +, b=11 −, op 00 -> result=6, carry=0, sign=1. Same operands with op 01 -> result=16, sign=0.
- Equal magnitudes: a=100 −, b=100 +, op 00 -> result=0, sign=0, carry=0.
- Pass ops: a=7 −, b=9 +, op 10 -> result=7, sign=1. Op 11 -> result=9, sign=0. carry=0 for both.
- Reset: drive rst_n low between edges while result is nonzero -> outputs go to 0 immediately. Deassert -> a new result appears after 1 edge.
